urx: RTL and testbench
======================

// Module: urx
// PURPOSE
//  UART serial receiver; the receiving end of the ttx transmitter link. Samples rx_in with a
//  16x-baud tick strobe, deserialises LSB-first 8-bit frames with optional even parity and
//  1 or 2 stop bits, and presents the byte plus per-frame error flags with a 1-cycle done strobe.
//  Sits between the pad/synchroniser and the byte-level interface (FIFO or control FSM).
// PARAMETERS
//  DBIT     8   data bits per frame
//  SB_TICK  16  tick strobes per bit period (oversampling ratio; must be even, >=4)
// PORTS
//  clk        in   1     system clock; all logic on rising edge
//  reset      in   1     synchronous, active-high reset
//  tick       in   1     baud strobe, one clk wide, SB_TICK per bit period
//  rx_in      in   1     serial line, idle high, asynchronous to clk
//  parity     in   1     1 = frame carries an even-parity bit after data
//  stop_bits  in   2     2'd2 or 2'd3 = two stop bits; 2'd0 or 2'd1 = one stop bit
//  d_out      out  DBIT  last received byte
//  rx_done    out  1     one-cycle pulse: frame complete, d_out/flags valid
//  parity_err out  1     last frame parity mismatch (0 if parity disabled)
//  frame_err  out  1     last frame had a 0 sampled in any stop bit
// BEHAVIOUR
//  - One clock, reset synchronous active-high. Reset: state IDLE, counters 0, d_out=0,
//    rx_done=0, parity_err=0, frame_err=0, both synchroniser flops=1 (idle line).
//  - rx_in passes through a 2-flop synchroniser; FSM uses only the synchronised value rxs.
//  - parity and stop_bits are latched on start detection; changes mid-frame are ignored.
//  - States: IDLE, START, DATA, PARITY, STOP. Tick counter s (0..SB_TICK-1), bit counter n.
//  - IDLE: rxs==0 -> START, s=0. No tick required for detection.
//  - START: on each tick s++; at s==SB_TICK/2-1 sample rxs: 0 -> DATA, s=0, n=0;
//    1 -> IDLE (glitch rejected, no outputs change).
//  - DATA: on tick, at s==SB_TICK-1 (mid-bit) shift rxs into MSB of shift reg, s=0, n++;
//    after DBIT bits -> PARITY if latched parity=1 else STOP.
//  - PARITY: sample at s==SB_TICK-1; parity error = XOR(data bits, sampled bit) != 0.
//  - STOP: sample at s==SB_TICK-1 per stop bit; any 0 sets frame error. After last stop bit
//    (1 or 2): register d_out, parity_err, frame_err; pulse rx_done; -> IDLE.
//  - rx_done high exactly one clk, the cycle after the final stop-bit sample edge.
//    d_out and flags hold until the next completed frame; aborted frames leave them unchanged.
//  - Frame error does not suppress rx_done or d_out update; a stop bit sampled 0 does not
//    start a new frame until the FSM returns to IDLE (line then re-checked next cycle).
//  - Clk cycles without tick: counters hold. tick coincident with state change: counted by
//    the new state only from the next tick.
//  - Reset mid-frame: abandon immediately, no rx_done, outputs to reset values.
// STRUCTURE
//  - Shared include uart_defs.vh: state encodings (shared with ttx), DBIT/SB_TICK defaults,
//    stop-bit decode constants.
//  - One sub-module: sync2 (2-flop synchroniser, reset value parameter). FSM, counters,
//    shift register and parity accumulator in urx itself.
// TESTING (SB_TICK=16, tick every 10 clk, ttx as stimulus source where possible)
//  - 0xFA, parity=1, stop_bits=1, parity bit 0 -> one rx_done, d_out=0xFA, both errs 0.
//  - 0xFA, parity=1, parity bit forced 1 -> rx_done, d_out=0xFA, parity_err=1, frame_err=0.
//  - 0x3C, parity=0, stop bit driven 0 -> rx_done, d_out=0x3C, frame_err=1.
//  - rx_in low for 4 ticks then high -> no rx_done, FSM back in IDLE, d_out unchanged.
//  - stop_bits=2, back-to-back 0x55 then 0xA3 -> two rx_done pulses, d_out 0x55 then 0xA3.
//  - reset=1 during DATA bit 3 -> no rx_done, outputs 0; next frame 0x81 received correctly.

Source files
------------

// File: rtl/urx_pkg.sv
// Shared definitions for the UART receiver.
//   - default frame geometry (data bits, oversampling ratio)
//   - receiver FSM state encoding
//   - stop_bits field decode
package urx_pkg;

   localparam int URX_DBIT    = 8;
   localparam int URX_SB_TICK = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } urx_state_t;

   localparam logic [1:0] STOP_TWO_A = 2'd2;
   localparam logic [1:0] STOP_TWO_B = 2'd3;

   function automatic logic stop_is_two(input logic [1:0] sb);
      return (sb == STOP_TWO_A) || (sb == STOP_TWO_B);
   endfunction

endpackage

// File: rtl/urx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, loads RST_VAL into both flops
//   d      asynchronous input
//   q      synchronised output
module urx_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/urx.sv
// UART serial receiver. Oversamples rx_in with a SB_TICK-per-bit strobe,
// deserialises LSB-first frames with optional even parity and 1 or 2 stop
// bits, and presents the byte plus error flags with a one-cycle rx_done.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   tick         oversampling strobe, one clk wide
//   rx_in        asynchronous serial line, idle high
//   parity       1 = even-parity bit follows the data (latched at start)
//   stop_bits    2/3 = two stop bits, 0/1 = one (latched at start)
//   d_out        last received byte
//   rx_done      one-cycle frame-complete pulse
//   parity_err   parity mismatch of last frame
//   frame_err    a stop bit of the last frame sampled 0
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge on rxs
// ST_START  | counting to mid start bit, re-checking it is still low
// ST_DATA   | sampling DBIT data bits at mid-bit
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling 1 or 2 stop bits, then publishing the frame
module urx
   import urx_pkg::*;
#(
   parameter int DBIT    = URX_DBIT,
   parameter int SB_TICK = URX_SB_TICK
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick,
   input  logic            rx_in,
   input  logic            parity,
   input  logic [1:0]      stop_bits,
   output logic [DBIT-1:0] d_out,
   output logic            rx_done,
   output logic            parity_err,
   output logic            frame_err
);

   localparam int SW = $clog2(SB_TICK);
   localparam int NW = (DBIT > 2) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_MID  = SW'(SB_TICK / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);

   logic rxs;

   urx_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_in),
      .q     (rxs)
   );

   urx_state_t      state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            par_en_q, par_en_d;
   logic            two_stop_q, two_stop_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic [DBIT-1:0] d_out_d;
   logic            rx_done_d, parity_err_d, frame_err_d;
   logic            last_stop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         n_q        <= '0;
         b_q        <= '0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         d_out      <= '0;
         rx_done    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         n_q        <= n_d;
         b_q        <= b_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         d_out      <= d_out_d;
         rx_done    <= rx_done_d;
         parity_err <= parity_err_d;
         frame_err  <= frame_err_d;
      end
   end

   assign last_stop = two_stop_q ? (n_q == N_ONE) : 1'b1;

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      par_en_d     = par_en_q;
      two_stop_d   = two_stop_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      d_out_d      = d_out;
      rx_done_d    = 1'b0;
      parity_err_d = parity_err;
      frame_err_d  = frame_err;

      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d    = ST_START;
               s_d        = '0;
               par_en_d   = parity;
               two_stop_d = stop_is_two(stop_bits);
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (s_q == S_MID) begin
                  s_d = '0;
                  if (!rxs) begin
                     state_d = ST_DATA;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (s_q == S_END) begin
                  s_d = '0;
                  b_d = {rxs, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     n_d     = '0;
                     state_d = par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_PARITY: begin
            if (tick) begin
               if (s_q == S_END) begin
                  s_d     = '0;
                  perr_d  = (^b_q) ^ rxs;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (s_q == S_END) begin
                  s_d    = '0;
                  ferr_d = ferr_q | ~rxs;
                  if (last_stop) begin
                     // Publish directly from the next-value so the final
                     // stop sample is included in frame_err.
                     n_d          = '0;
                     state_d      = ST_IDLE;
                     d_out_d      = b_q;
                     parity_err_d = perr_q;
                     frame_err_d  = ferr_q | ~rxs;
                     rx_done_d    = 1'b1;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_urx.sv
module tb_urx;

   localparam int BIT_CLKS = 160;   // 16 ticks x 10 clk

   logic       clk = 1'b0;
   logic       reset;
   logic       tick = 1'b0;
   logic       rx_in;
   logic       parity;
   logic [1:0] stop_bits;
   logic [7:0] d_out;
   logic       rx_done;
   logic       parity_err;
   logic       frame_err;

   int total = 0;
   int bad   = 0;
   int tcnt  = 0;

   logic [7:0] cap_d[$];
   logic       cap_pe[$];
   logic       cap_fe[$];

   urx dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .rx_in      (rx_in),
      .parity     (parity),
      .stop_bits  (stop_bits),
      .d_out      (d_out),
      .rx_done    (rx_done),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // tick: one clk wide every 10 clk, changed on the falling edge
   always @(negedge clk) begin
      tcnt = (tcnt == 9) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
   end

   // every rx_done high cycle is one capture; a stuck pulse shows up as extras
   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         cap_d.push_back(d_out);
         cap_pe.push_back(parity_err);
         cap_fe.push_back(frame_err);
      end
   end

   task automatic drive(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_val,
                             input int nstop, input bit stop_ok);
      drive(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
      if (par_en) drive(par_val, BIT_CLKS);
      for (int i = 0; i < nstop; i++) begin
         if (stop_ok) drive(1'b1, BIT_CLKS);
         else begin
            drive(1'b0, 120);
            drive(1'b1, 40);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; rx_in = 1'b1; parity = 1'b0; stop_bits = 2'd0;
      repeat (4) @(negedge clk);
      total++; if (d_out !== 8'h00)   begin bad++; $display("FAIL reset_d_out got=%h exp=00", d_out); end
      total++; if (rx_done !== 1'b0)  begin bad++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      reset = 1'b0;
      drive(1'b1, 200);
   endtask

   task automatic test_good_parity;
      int base;
      base = cap_d.size();
      parity = 1'b1; stop_bits = 2'd1;
      send_frame(8'hFA, 1'b1, 1'b0, 1, 1'b1);
      drive(1'b1, 320);
      total++; if (cap_d.size() !== base + 1) begin bad++; $display("FAIL good_par_count got=%0d exp=%0d", cap_d.size() - base, 1); end
      else begin
         total++; if (cap_d[base] !== 8'hFA) begin bad++; $display("FAIL good_par_d got=%h exp=fa", cap_d[base]); end
         total++; if (cap_pe[base] !== 1'b0) begin bad++; $display("FAIL good_par_perr got=%b exp=0", cap_pe[base]); end
         total++; if (cap_fe[base] !== 1'b0) begin bad++; $display("FAIL good_par_ferr got=%b exp=0", cap_fe[base]); end
      end
   endtask

   task automatic test_bad_parity;
      int base;
      base = cap_d.size();
      parity = 1'b1; stop_bits = 2'd1;
      send_frame(8'hFA, 1'b1, 1'b1, 1, 1'b1);
      drive(1'b1, 320);
      total++; if (cap_d.size() !== base + 1) begin bad++; $display("FAIL bad_par_count got=%0d exp=%0d", cap_d.size() - base, 1); end
      else begin
         total++; if (cap_d[base] !== 8'hFA) begin bad++; $display("FAIL bad_par_d got=%h exp=fa", cap_d[base]); end
         total++; if (cap_pe[base] !== 1'b1) begin bad++; $display("FAIL bad_par_perr got=%b exp=1", cap_pe[base]); end
         total++; if (cap_fe[base] !== 1'b0) begin bad++; $display("FAIL bad_par_ferr got=%b exp=0", cap_fe[base]); end
      end
      // flags hold between frames
      total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL bad_par_hold got=%b exp=1", parity_err); end
   endtask

   task automatic test_frame_err;
      int base;
      base = cap_d.size();
      // parity input toggled mid-frame must be ignored (latched 0 at start)
      parity = 1'b0; stop_bits = 2'd0;
      fork
         send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
         begin
            repeat (400) @(negedge clk);
            parity = 1'b1;
         end
      join
      parity = 1'b0;
      drive(1'b1, 320);
      total++; if (cap_d.size() !== base + 1) begin bad++; $display("FAIL ferr_count got=%0d exp=%0d", cap_d.size() - base, 1); end
      else begin
         total++; if (cap_d[base] !== 8'h3C) begin bad++; $display("FAIL ferr_d got=%h exp=3c", cap_d[base]); end
         total++; if (cap_fe[base] !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", cap_fe[base]); end
         total++; if (cap_pe[base] !== 1'b0) begin bad++; $display("FAIL ferr_perr got=%b exp=0", cap_pe[base]); end
      end
   endtask

   task automatic test_glitch;
      int base;
      base = cap_d.size();
      drive(1'b0, 40);
      drive(1'b1, 400);
      total++; if (cap_d.size() !== base) begin bad++; $display("FAIL glitch_count got=%0d exp=0", cap_d.size() - base); end
      total++; if (d_out !== 8'h3C) begin bad++; $display("FAIL glitch_d_hold got=%h exp=3c", d_out); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL glitch_ferr_hold got=%b exp=1", frame_err); end
   endtask

   task automatic test_back_to_back;
      int base;
      base = cap_d.size();
      parity = 1'b0; stop_bits = 2'd2;
      send_frame(8'h55, 1'b0, 1'b0, 2, 1'b1);
      send_frame(8'hA3, 1'b0, 1'b0, 2, 1'b1);
      drive(1'b1, 320);
      total++; if (cap_d.size() !== base + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", cap_d.size() - base); end
      else begin
         total++; if (cap_d[base] !== 8'h55)     begin bad++; $display("FAIL b2b_d0 got=%h exp=55", cap_d[base]); end
         total++; if (cap_d[base+1] !== 8'hA3)   begin bad++; $display("FAIL b2b_d1 got=%h exp=a3", cap_d[base+1]); end
         total++; if (cap_fe[base+1] !== 1'b0)   begin bad++; $display("FAIL b2b_ferr got=%b exp=0", cap_fe[base+1]); end
         total++; if (cap_pe[base+1] !== 1'b0)   begin bad++; $display("FAIL b2b_perr got=%b exp=0", cap_pe[base+1]); end
      end
   endtask

   task automatic test_reset_mid;
      int base;
      logic [7:0] d;
      base = cap_d.size();
      d = 8'hF6;
      parity = 1'b0; stop_bits = 2'd0;
      drive(1'b0, BIT_CLKS);
      for (int i = 0; i < 3; i++) drive(d[i], BIT_CLKS);
      drive(d[3], 80);
      reset = 1'b1;
      @(negedge clk);
      total++; if (d_out !== 8'h00)     begin bad++; $display("FAIL rstmid_d_out got=%h exp=00", d_out); end
      total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rstmid_perr got=%b exp=0", parity_err); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 400);
      total++; if (cap_d.size() !== base) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", cap_d.size() - base); end
      send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1);
      drive(1'b1, 320);
      total++; if (cap_d.size() !== base + 1) begin bad++; $display("FAIL rstmid_next_count got=%0d exp=1", cap_d.size() - base); end
      else begin
         total++; if (cap_d[base] !== 8'h81) begin bad++; $display("FAIL rstmid_next_d got=%h exp=81", cap_d[base]); end
         total++; if (cap_fe[base] !== 1'b0) begin bad++; $display("FAIL rstmid_next_ferr got=%b exp=0", cap_fe[base]); end
      end
   endtask

   initial begin
      test_reset();
      test_good_parity();
      test_bad_parity();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
